// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
//
// Purpose:
//   Coprocessor-0 register file for the MIPS core. Commits the exception /
//   ERET decision made in the M stage (EPC, Cause.BD, Cause.ExcCode,
//   Status.EXL, BadVAddr), services MTC0 writes and MFC0 reads, samples the
//   hardware interrupt lines into Cause.IP[7:2] and, optionally, implements
//   the Count/Compare timer.
//
// Configuration macro:
//   CP0_TIMER_EN  - when defined, Count/Compare/TI are implemented and TI is
//                   ORed into Cause.IP7. When undefined, Count, Compare and
//                   TI read as constant 0, MTC0 to 9/11 is ignored and
//                   Cause[15] follows ext_int[5] only.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   we_i, waddr_i,   MTC0 write (enable, register number, data); takes
//   data_i           effect at the next clk edge
//   raddr_i, data_o  MFC0 read; data_o is combinational, no write bypass
//   ext_int          hardware interrupt lines -> Cause[15:10] every cycle
//   is_except,       exception/ERET commit from the M-stage decoder
//   except_type,
//   current_pc,
//   is_in_delayslot,
//   bad_addr
//   status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o
//                    architectural register values
//   timer_int_o      Cause.TI
//
// Handshake note: there is no valid/ready pairing here. we_i and is_except
//   are single-cycle qualifiers sampled at the clk edge; a commit
//   (is_except=1) in the same cycle as we_i drops the MTC0 completely,
//   since the writing instruction is being flushed.
// ---------------------------------------------------------------------------
module cp0_regfile #(
  parameter logic [31:0] PRID = 32'h00004220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [5:0]  ext_int,
  input  logic        is_except,
  input  logic [31:0] except_type,
  input  logic [31:0] current_pc,
  input  logic        is_in_delayslot,
  input  logic [31:0] bad_addr,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;  // BEV=1
  // Software-writable bits: Status IM[15:8], EXL, IE; Cause IP[9:8].
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  logic [31:0] status_q,   status_d;
  logic [31:0] cause_q,    cause_d;
  logic [31:0] epc_q,      epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic        tick_q,     tick_d;
`endif

  // MTC0 only lands when no commit is happening in the same cycle.
  logic mtc0_ok;
  assign mtc0_ok = we_i && !is_except;

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
`ifdef CP0_TIMER_EN
    count_d    = count_q;
    compare_d  = compare_q;
    tick_d     = tick_q;
`endif

    if (is_except) begin
      if (except_type == EXC_ERET) begin
        status_d[1] = 1'b0;
      end else begin
        // Nested exceptions (EXL already set) keep the original EPC/BD so
        // the handler can still return to the first faulting instruction.
        if (!status_q[1]) begin
          epc_d       = is_in_delayslot ? (current_pc - 32'd4) : current_pc;
          cause_d[31] = is_in_delayslot;
        end
        status_d[1]   = 1'b1;
        cause_d[6:2]  = except_type[4:0];
        if (except_type == EXC_ADEL || except_type == EXC_ADES) begin
          badvaddr_d = bad_addr;
        end
      end
    end else if (mtc0_ok) begin
      case (waddr_i)
        REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        REG_CAUSE:  cause_d  = (cause_q  & ~CAUSE_WMASK)  | (data_i & CAUSE_WMASK);
        REG_EPC:    epc_d    = data_i;
        default: ;
      endcase
    end

    // Hardware interrupt lines are sampled every cycle, commit or not.
    cause_d[15:10] = ext_int;

`ifdef CP0_TIMER_EN
    // Count advances on every second edge; an MTC0 to Count restarts the
    // phase so the first increment comes two edges after the write.
    if (mtc0_ok && waddr_i == REG_COUNT) begin
      count_d = data_i;
      tick_d  = 1'b0;
    end else begin
      tick_d = ~tick_q;
      if (tick_q) begin
        count_d = count_q + 32'd1;
      end
    end

    if (mtc0_ok && waddr_i == REG_COMPARE) begin
      compare_d = data_i;
    end

    // TI: set on a Count==Compare cycle, cleared by writing Compare; the
    // clear is checked last so it wins a same-cycle collision.
    if (count_q == compare_q) begin
      cause_d[30] = 1'b1;
    end
    if (mtc0_ok && waddr_i == REG_COMPARE) begin
      cause_d[30] = 1'b0;
    end

    cause_d[15] = ext_int[5] | cause_q[30];
`else
    cause_d[30] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
`ifdef CP0_TIMER_EN
      count_q    <= '0;
      compare_q  <= '0;
      tick_q     <= 1'b0;
`endif
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
`ifdef CP0_TIMER_EN
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
`endif
    end
  end

  assign status_o   = status_q;
  assign cause_o    = cause_q;
  assign epc_o      = epc_q;
  assign badvaddr_o = badvaddr_q;
  assign timer_int_o = cause_q[30];
`ifdef CP0_TIMER_EN
  assign count_o    = count_q;
  assign compare_o  = compare_q;
`else
  assign count_o    = '0;
  assign compare_o  = '0;
`endif

  // MFC0 read mux: current register state only, no bypass of a pending write.
  always_comb begin
    data_o = '0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_o;
      REG_COUNT:    data_o = count_o;
      REG_COMPARE:  data_o = compare_o;
      REG_STATUS:   data_o = status_q;
      REG_CAUSE:    data_o = cause_q;
      REG_EPC:      data_o = epc_q;
      REG_PRID:     data_o = PRID;
      default:      data_o = '0;
    endcase
  end

endmodule
